// File: rtl/music_seq.sv
// Note-table music sequencer: per-note period division, PWM tone, tempo-scaled length, articulation gap.
// Define MUSIC_SEQ_LOOP_EN to make the sequence restart from note 0 after each done pulse.
module music_seq #(
  parameter int CLK_FREQ  = 50000000,
  parameter int DEPTH     = 32,
  parameter int IDX_W     = 5,
  parameter int GAP_TICKS = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      unit_ticks,
  input  logic [1:0]       vol,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [11:0]      wr_freq,
  input  logic [7:0]       wr_len,
  output logic             music,
  output logic             busy,
  output logic [IDX_W-1:0] note_idx,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(DEPTH - 1);

  state_t state, state_nxt;

  logic [11:0] freq_mem [DEPTH];
  logic [7:0]  len_mem  [DEPTH];

  logic [11:0] freq_r;
  logic [7:0]  len_r;
  logic [11:0] rem;
  logic [31:0] quo;
  logic [5:0]  cnt;
  logic [31:0] period, duty, target, pwm, dur;

  // Table has no reset so contents survive rst; rst still blocks writes.
  always_ff @(posedge clk)
    if (!rst && wr_en && (32'(wr_addr) < 32'(DEPTH))) begin
      freq_mem[wr_addr] <= wr_freq;
      len_mem[wr_addr]  <= wr_len;
    end

  // One restoring-divider step: remainder stays below the 12-bit divisor.
  logic [12:0] rem_sh;
  logic        ge;
  logic [11:0] rem_dif, rem_nxt;
  logic [31:0] quo_nxt, per_c, duty_c, ut_e, tgt_c;
  logic [7:0]  len_e;
  logic [39:0] prod;
  logic [IDX_W-1:0] last_eff;
  logic play_end, gap_end, load_end, last_note;

  always_comb begin
    rem_sh   = {rem, quo[31]};
    ge       = rem_sh >= {1'b0, freq_r};
    rem_dif  = rem_sh[11:0] - freq_r;
    rem_nxt  = ge ? rem_dif : rem_sh[11:0];
    quo_nxt  = {quo[30:0], ge};
    per_c    = (quo_nxt < 32'd2) ? 32'd2 : quo_nxt;
    duty_c   = per_c >> (3'(vol) + 3'd1);
    len_e    = (len_r == 8'd0) ? 8'd1 : len_r;
    ut_e     = (unit_ticks == 32'd0) ? 32'd1 : unit_ticks;
    prod     = 40'(len_e) * 40'(ut_e);
    tgt_c    = (|prod[39:32]) ? 32'hFFFF_FFFF : prod[31:0];
    last_eff = (32'(last_idx) >= 32'(DEPTH)) ? LAST_MAX : last_idx;
    load_end  = cnt == 6'd32;
    play_end  = ({1'b0, dur} + 33'd1) >= {1'b0, target};
    gap_end   = dur >= 32'(GAP_TICKS - 1);
    last_note = note_idx == last_eff;
  end

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (stop) state_nxt = IDLE;
    else
      case (state)
        IDLE: if (start) state_nxt = LOAD;
        LOAD: if (load_end) state_nxt = PLAY;
        PLAY: if (play_end)
                state_nxt = (GAP_TICKS != 0) ? GAP : (last_note ? DONE : LOAD);
        GAP:  if (gap_end) state_nxt = last_note ? DONE : LOAD;
`ifdef MUSIC_SEQ_LOOP_EN
        DONE: state_nxt = LOAD;
`else
        DONE: state_nxt = IDLE;
`endif
        default: state_nxt = IDLE;
      endcase
  end

  always_comb begin
    music = (state == PLAY) && (freq_r != 12'd0) && (pwm < duty);
    busy  = state != IDLE;
    done  = state == DONE;
  end

  always_ff @(posedge clk)
    if (rst) begin
      freq_r <= '0; len_r <= '0; rem <= '0; quo <= '0; cnt <= '0;
      period <= '0; duty <= '0; target <= '0; pwm <= '0; dur <= '0;
      note_idx <= '0;
    end else begin
      cnt <= (state == LOAD && state_nxt == LOAD) ? cnt + 6'd1 : 6'd0;
      case (state)
        LOAD:
          if (cnt == 6'd0) begin
            freq_r <= freq_mem[note_idx];
            len_r  <= len_mem[note_idx];
            rem    <= '0;
            quo    <= 32'(CLK_FREQ);
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (load_end) begin
              period <= per_c;
              duty   <= duty_c;
              target <= tgt_c;
              pwm    <= '0;
              dur    <= '0;
            end
          end
        PLAY: begin
          pwm <= (pwm >= period - 32'd1) ? 32'd0 : pwm + 32'd1;
          dur <= play_end ? 32'd0 : ((&dur) ? dur : dur + 32'd1);
        end
        GAP: dur <= (&dur) ? dur : dur + 32'd1;
        default: ;
      endcase
      if (state_nxt == LOAD && state != LOAD)
        note_idx <= (state == PLAY || state == GAP) ? note_idx + 1'b1 : '0;
    end
endmodule

// File: tb/tb_music_seq.sv
// Directed + randomized bench for music_seq; expected waveforms come from a note-level timing model.
module tb_music_seq;
  localparam int CLK_FREQ = 1000000;
  localparam int DEPTH    = 20;
  localparam int IDX_W    = 5;
  localparam int GAP      = 20;

  logic clk = 1'b0;
  logic rst, start, stop, wr_en, music, busy, done;
  logic [31:0] unit_ticks;
  logic [1:0]  vol;
  logic [IDX_W-1:0] last_idx, wr_addr, note_idx;
  logic [11:0] wr_freq;
  logic [7:0]  wr_len;

  int n_chk = 0, n_fail = 0;
  int tf [DEPTH];
  int tl [DEPTH];

  music_seq #(.CLK_FREQ(CLK_FREQ), .DEPTH(DEPTH), .IDX_W(IDX_W), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .unit_ticks(unit_ticks), .vol(vol),
    .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq), .wr_len(wr_len),
    .music(music), .busy(busy), .note_idx(note_idx), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-cycle strobes are dropped at the negedge after the posedge that sampled them.
  task automatic tick();
    @(negedge clk);
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wr(input int a, input int f, input int l);
    wr_en = 1'b1; wr_addr = IDX_W'(a); wr_freq = 12'(f); wr_len = 8'(l);
    tf[a] = f; tl[a] = l;
    tick();
  endtask

  task automatic chk_cycle(input string ph, input int idx, input logic m, input logic d, input logic b);
    chk({ph, "_music"}, music, m);
    chk({ph, "_done"}, done, d);
    chk({ph, "_busy"}, busy, b);
    chk({ph, "_idx"}, note_idx, idx);
  endtask

  // Model: 33 load cycles, len*ut play cycles of PWM (period=max(2,CLK/f), duty=period>>(vol+1)),
  // GAP silent cycles, one done cycle.
  task automatic run_seq(input int last, input int v, input int ut, input int rounds,
                         input bit mid_wr, input int new_f);
    int le, per, dty, pl, f, l;
    le = (last >= DEPTH) ? DEPTH - 1 : last;
    last_idx = IDX_W'(last); vol = 2'(v); unit_ticks = ut;
    start = 1'b1;
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i <= le; i++) begin
        f = tf[i]; l = tl[i];
        repeat (33) begin tick(); chk_cycle("load", i, 1'b0, 1'b0, 1'b1); end
        per = (f == 0) ? 2 : CLK_FREQ / f;
        if (per < 2) per = 2;
        dty = per >> (v + 1);
        pl = ((l == 0) ? 1 : l) * ((ut == 0) ? 1 : ut);
        for (int k = 0; k < pl; k++) begin
          tick();
          chk_cycle("play", i, (f != 0) && ((k % per) < dty), 1'b0, 1'b1);
          if (mid_wr && r == 0 && i == 0 && k == 10) begin
            wr_en = 1'b1; wr_addr = '0; wr_freq = 12'(new_f); wr_len = 8'(tl[0]);
            tf[0] = new_f;
          end
        end
        repeat (GAP) begin tick(); chk_cycle("gap", i, 1'b0, 1'b0, 1'b1); end
      end
      tick(); chk_cycle("done", le, 1'b0, 1'b1, 1'b1);
    end
`ifdef MUSIC_SEQ_LOOP_EN
    stop = 1'b1;
`endif
    tick();
    chk("end_busy", busy, 1'b0);
    chk("end_done", done, 1'b0);
    chk("end_music", music, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0; unit_ticks = '0; vol = '0;
    last_idx = '0; wr_addr = '0; wr_freq = '0; wr_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_music", music, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_idx", note_idx, 0);
    rst = 1'b0;

    // Single 1 kHz note, full and quietest volume
    wr(0, 1000, 2);
    run_seq(0, 0, 500, 1, 1'b0, 0);
    run_seq(0, 3, 500, 1, 1'b0, 0);
    // Rest as second note
    wr(1, 0, 1);
    run_seq(1, 0, 500, 1, 1'b0, 0);

    // Stop 100 cycles into PLAY
    last_idx = '0; vol = '0; unit_ticks = 500; start = 1'b1;
    repeat (133) tick();
    chk("stop_pre_music", music, 1'b1);
    stop = 1'b1;
    tick();
    chk("stop_busy", busy, 1'b0);
    chk("stop_music", music, 1'b0);
    repeat (5) begin tick(); chk("stop_done", done, 1'b0); end

    // rst with start and a write mid-sequence: write must be blocked, table kept
    last_idx = 5'd1; unit_ticks = 500; start = 1'b1;
    repeat (83) tick();
    rst = 1'b1; start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_freq = 12'd3000; wr_len = 8'd9;
    tick();
    rst = 1'b0;
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_music", music, 1'b0);
    chk("rst2_done", done, 1'b0);
    chk("rst2_idx", note_idx, 0);
    run_seq(1, 1, 30, 1, 1'b0, 0);

    // Write to the playing entry lands only at its next LOAD
    run_seq(0, 2, 40, 1, 1'b1, 2000);
    run_seq(0, 2, 40, 1, 1'b0, 0);

    // Randomized tables and tempos
    repeat (4) begin
      for (int i = 0; i < 6; i++)
        wr(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(200, 4095)),
           int'($urandom_range(0, 3)));
      run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 40)), 1, 1'b0, 0);
    end

    // Out-of-range last_idx clamps to DEPTH-1; len=0 and unit_ticks=0 act as 1
    for (int i = 0; i < DEPTH; i++) wr(i, 300 + i * 150, (i == 3) ? 0 : 1);
    run_seq(25, 1, 0, 1, 1'b0, 0);

`ifdef MUSIC_SEQ_LOOP_EN
    run_seq(1, 0, 10, 2, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
